// File: rtl/race_controller_if.sv
// Signal bundle between the race sequencer and its neighbours: start button,
// checkpoint-tracker levels in, race status and timers out to car control and HUD.
interface race_controller_if;
  logic        start;
  logic        lap_finished;
  logic        checkpoints_passed;
  logic [1:0]  race_state;
  logic [1:0]  countdown;
  logic        car_enable;
  logic        checkpoint_clr;
  logic [2:0]  lap_count;
  logic [13:0] lap_time;
  logic [13:0] best_lap;
  logic [15:0] race_time;
  logic        race_done;

  modport slave (
    input  start, lap_finished, checkpoints_passed,
    output race_state, countdown, car_enable, checkpoint_clr,
           lap_count, lap_time, best_lap, race_time, race_done
  );

  modport master (
    output start, lap_finished, checkpoints_passed,
    input  race_state, countdown, car_enable, checkpoint_clr,
           lap_count, lap_time, best_lap, race_time, race_done
  );
endinterface

// File: rtl/race_controller.sv
// Race sequencer: start countdown, car gating, lap validation and 10 ms lap/best/race timers.
//   state       | meaning
//   S_IDLE      | waiting for a start press, outputs at reset values
//   S_COUNTDOWN | 3-2-1 countdown, one digit per 100 ticks
//   S_RACING    | car enabled, timers running, laps validated
//   S_FINISHED  | all laps done, results frozen until the next start press
module race_controller #(
  parameter int LAPS     = 3,
  parameter int TICK_DIV = 650000
) (
  input  logic            pclk,
  input  logic            rst,
  race_controller_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [13:0] LAP_MAX  = 14'd9999;
  localparam logic [15:0] RACE_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_RACING    = 2'd2,
    S_FINISHED  = 2'd3
  } state_t;

  state_t        state;
  logic          start_q;
  logic          fin_q;
  logic [PW-1:0] presc;
  logic [6:0]    sub_cnt;
  logic [1:0]    countdown;
  logic          car_enable;
  logic          checkpoint_clr;
  logic [2:0]    lap_count;
  logic [13:0]   lap_time;
  logic [13:0]   best_lap;
  logic [15:0]   race_time;
  logic          race_done;

  logic start_rise;
  logic fin_rise;
  logic tick;
  logic enter_cd;
  logic valid_lap;

  assign start_rise = bus.start & ~start_q;
  assign fin_rise   = bus.lap_finished & ~fin_q;
  assign tick       = (presc == PW'(TICK_DIV - 1));
  assign enter_cd   = start_rise & ((state == S_IDLE) | (state == S_FINISHED));
  assign valid_lap  = fin_rise & bus.checkpoints_passed;

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state          <= S_IDLE;
      start_q        <= 1'b1;
      fin_q          <= 1'b1;
      presc          <= '0;
      sub_cnt        <= '0;
      countdown      <= 2'd0;
      car_enable     <= 1'b0;
      checkpoint_clr <= 1'b0;
      lap_count      <= 3'd0;
      lap_time       <= 14'd0;
      best_lap       <= LAP_MAX;
      race_time      <= 16'd0;
      race_done      <= 1'b0;
    end else begin
      start_q        <= bus.start;
      fin_q          <= bus.lap_finished;
      presc          <= tick ? '0 : presc + PW'(1);
      checkpoint_clr <= 1'b0;

      if (enter_cd) begin
        // Prescaler restarts here so the countdown is exactly 300 ticks long.
        state          <= S_COUNTDOWN;
        presc          <= '0;
        sub_cnt        <= '0;
        countdown      <= 2'd3;
        car_enable     <= 1'b0;
        checkpoint_clr <= 1'b1;
        lap_count      <= 3'd0;
        lap_time       <= 14'd0;
        best_lap       <= LAP_MAX;
        race_time      <= 16'd0;
        race_done      <= 1'b0;
      end else begin
        case (state)
          S_COUNTDOWN: begin
            if (tick) begin
              if (sub_cnt == 7'd99) begin
                sub_cnt <= '0;
                if (countdown == 2'd1) begin
                  state      <= S_RACING;
                  countdown  <= 2'd0;
                  car_enable <= 1'b1;
                end else begin
                  countdown <= countdown - 2'd1;
                end
              end else begin
                sub_cnt <= sub_cnt + 7'd1;
              end
            end
          end
          S_RACING: begin
            if (tick && race_time != RACE_MAX)
              race_time <= race_time + 16'd1;
            // A lap on a tick edge records the pre-tick time and drops that tick.
            if (valid_lap) begin
              if (lap_time < best_lap)
                best_lap <= lap_time;
              lap_count      <= lap_count + 3'd1;
              lap_time       <= 14'd0;
              checkpoint_clr <= 1'b1;
              if (lap_count + 3'd1 == 3'(LAPS)) begin
                state      <= S_FINISHED;
                car_enable <= 1'b0;
                race_done  <= 1'b1;
              end
            end else if (tick && lap_time != LAP_MAX) begin
              lap_time <= lap_time + 14'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.race_state     = state;
  assign bus.countdown      = countdown;
  assign bus.car_enable     = car_enable;
  assign bus.checkpoint_clr = checkpoint_clr;
  assign bus.lap_count      = lap_count;
  assign bus.lap_time       = lap_time;
  assign bus.best_lap       = best_lap;
  assign bus.race_time      = race_time;
  assign bus.race_done      = race_done;

endmodule

// File: tb/tb_race_controller.sv
// Bench for race_controller: hand-derived vector table plus a per-cycle elapsed-time model under random stimulus.
module tb_race_controller;
  localparam int TD   = 4;
  localparam int LAPS = 2;

  logic pclk;
  logic rst;
  race_controller_if bus ();

  race_controller #(.LAPS(LAPS), .TICK_DIV(TD)) dut (
    .pclk(pclk),
    .rst (rst),
    .bus (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_on  = 1'b0;

  // Reference model: phase plus edges elapsed since the countdown began.
  int m_phase, m_k, m_laps, m_best, m_last, m_frozen, m_clr;
  bit m_pstart, m_pfin;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_step();
    bit sr, fr;
    int rt, lt_pre;
    if (!rst) begin
      m_phase = 0; m_k = 0; m_laps = 0; m_best = 9999; m_last = 0;
      m_frozen = 0; m_clr = 0; m_pstart = 1'b1; m_pfin = 1'b1;
      return;
    end
    sr = bus.start && !m_pstart;
    fr = bus.lap_finished && !m_pfin;
    m_pstart = bus.start;
    m_pfin   = bus.lap_finished;
    m_clr    = 0;
    if ((m_phase == 0 || m_phase == 3) && sr) begin
      m_phase = 1; m_k = 0; m_laps = 0; m_best = 9999; m_last = 0;
      m_frozen = 0; m_clr = 1;
    end else if (m_phase == 1) begin
      m_k++;
      if (m_k / TD == 300) m_phase = 2;
    end else if (m_phase == 2) begin
      m_k++;
      rt = m_k / TD - 300;
      if (fr && bus.checkpoints_passed) begin
        lt_pre = imin((m_k - 1) / TD - 300 - m_last, 9999);
        m_best = imin(m_best, lt_pre);
        m_laps++;
        m_last = rt;
        m_clr  = 1;
        if (m_laps == LAPS) begin
          m_phase  = 3;
          m_frozen = imin(rt, 65535);
        end
      end
    end
  endtask

  task automatic check_model();
    int e_lt, e_rt, e_cd;
    e_cd = (m_phase == 1) ? 3 - (m_k / TD) / 100 : 0;
    e_lt = (m_phase == 2) ? imin(m_k / TD - 300 - m_last, 9999) : 0;
    e_rt = (m_phase == 2) ? imin(m_k / TD - 300, 65535) : (m_phase == 3) ? m_frozen : 0;
    chk("model race_state", int'(bus.race_state), m_phase);
    chk("model countdown", int'(bus.countdown), e_cd);
    chk("model car_enable", int'(bus.car_enable), (m_phase == 2) ? 1 : 0);
    chk("model race_done", int'(bus.race_done), (m_phase == 3) ? 1 : 0);
    chk("model checkpoint_clr", int'(bus.checkpoint_clr), m_clr);
    chk("model lap_count", int'(bus.lap_count), m_laps);
    chk("model lap_time", int'(bus.lap_time), e_lt);
    chk("model best_lap", int'(bus.best_lap), m_best);
    chk("model race_time", int'(bus.race_time), e_rt);
  endtask

  initial forever begin
    @(posedge pclk);
    model_step();
  end

  initial forever begin
    @(negedge pclk);
    if (chk_on) check_model();
  end

  typedef struct {
    int rst, start, fin, cp, cycles;
    int state, cd, car, laps, lt, best, rt, clr, done;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // rst start fin cp cycles | state cd car laps lt best rt clr done
    vecs.push_back('{0,0,0,0,3,     0,0,0,0,0,9999,0,0,0});     // reset
    vecs.push_back('{1,0,0,0,2,     0,0,0,0,0,9999,0,0,0});     // idle
    vecs.push_back('{1,1,0,0,1,     1,3,0,0,0,9999,0,1,0});     // start press
    vecs.push_back('{1,1,0,0,1,     1,3,0,0,0,9999,0,0,0});     // clr is one cycle
    vecs.push_back('{1,1,0,0,1198,  1,1,0,0,0,9999,0,0,0});     // last countdown cycle
    vecs.push_back('{1,1,0,0,1,     2,0,1,0,0,9999,0,0,0});     // racing after 1200
    vecs.push_back('{1,1,1,0,4,     2,0,1,0,1,9999,1,0,0});     // invalid lap ignored
    vecs.push_back('{1,1,0,0,144,   2,0,1,0,37,9999,37,0,0});
    vecs.push_back('{1,1,1,1,1,     2,0,1,1,0,37,37,1,0});      // lap at 37
    vecs.push_back('{1,1,1,1,3,     2,0,1,1,1,37,38,0,0});      // held fin counts once
    vecs.push_back('{1,1,0,0,97,    2,0,1,1,25,37,62,0,0});
    vecs.push_back('{1,1,1,1,1,     3,0,0,2,0,25,62,1,1});      // lap at 25, finish
    vecs.push_back('{1,1,0,0,20,    3,0,0,2,0,25,62,0,1});      // frozen
    vecs.push_back('{1,0,0,0,1,     3,0,0,2,0,25,62,0,1});
    vecs.push_back('{1,1,0,0,1,     1,3,0,0,0,9999,0,1,0});     // restart clears all
    vecs.push_back('{1,0,0,0,1200,  2,0,1,0,0,9999,0,0,0});
    vecs.push_back('{1,0,0,0,43,    2,0,1,0,10,9999,10,0,0});
    vecs.push_back('{1,0,1,1,1,     2,0,1,1,0,10,11,1,0});      // lap on a tick edge
    vecs.push_back('{1,0,0,0,39992, 2,0,1,1,9998,10,10009,0,0});
    vecs.push_back('{1,0,0,0,4,     2,0,1,1,9999,10,10010,0,0}); // lap_time saturates
    vecs.push_back('{1,0,0,0,4,     2,0,1,1,9999,10,10011,0,0});
    vecs.push_back('{0,1,0,0,1,     0,0,0,0,0,9999,0,0,0});     // mid-race reset
    vecs.push_back('{1,1,0,0,10,    0,0,0,0,0,9999,0,0,0});     // held start ignored
    vecs.push_back('{1,0,0,0,1,     0,0,0,0,0,9999,0,0,0});
    vecs.push_back('{1,1,0,0,1,     1,3,0,0,0,9999,0,1,0});
    vecs.push_back('{1,1,0,0,500,   1,2,0,0,0,9999,0,0,0});
    vecs.push_back('{0,0,0,0,1,     0,0,0,0,0,9999,0,0,0});     // mid-countdown reset

    rst = 1'b0;
    bus.start = 1'b0;
    bus.lap_finished = 1'b0;
    bus.checkpoints_passed = 1'b0;
    @(negedge pclk);
    chk_on = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst                    = (vecs[i].rst != 0);
      bus.start              = (vecs[i].start != 0);
      bus.lap_finished       = (vecs[i].fin != 0);
      bus.checkpoints_passed = (vecs[i].cp != 0);
      repeat (vecs[i].cycles) @(negedge pclk);
      chk($sformatf("vec%0d race_state", i), int'(bus.race_state), vecs[i].state);
      chk($sformatf("vec%0d countdown", i), int'(bus.countdown), vecs[i].cd);
      chk($sformatf("vec%0d car_enable", i), int'(bus.car_enable), vecs[i].car);
      chk($sformatf("vec%0d lap_count", i), int'(bus.lap_count), vecs[i].laps);
      chk($sformatf("vec%0d lap_time", i), int'(bus.lap_time), vecs[i].lt);
      chk($sformatf("vec%0d best_lap", i), int'(bus.best_lap), vecs[i].best);
      chk($sformatf("vec%0d race_time", i), int'(bus.race_time), vecs[i].rt);
      chk($sformatf("vec%0d checkpoint_clr", i), int'(bus.checkpoint_clr), vecs[i].clr);
      chk($sformatf("vec%0d race_done", i), int'(bus.race_done), vecs[i].done);
    end

    // Random phase: occasional resets, start toggles and finish-zone crossings.
    rst = 1'b1;
    for (int c = 0; c < 9000; c++) begin
      rst = ($urandom_range(0, 699) != 0);
      if ($urandom_range(0, 149) == 0) bus.start = ~bus.start;
      if ($urandom_range(0, 5) == 0) bus.lap_finished = ~bus.lap_finished;
      bus.checkpoints_passed = ($urandom_range(0, 2) != 0);
      @(negedge pclk);
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
